usb_packet_fsm: RTL and testbench

Parametrised successor to the single-packet USB link controller FSM. It sequences receive and transmit of one USB packet at a time over the bit-level RX/TX datapath. It adds a configurable sync pattern and payload depth, a receive byte counter with overflow detection, an idle-line timeout, length-driven transmit in place of a `data_sent` strobe, and an encoded error cause. It sits between the NRZI/bit-stuff datapath and the packet FIFOs.

---
 rtl/usb_ctrl_pkg.sv | 65 ++++++
 rtl/usb_timeout_counter.sv | 26 ++
 rtl/usb_packet_fsm.sv | 164 ++++++++++++++++
 tb/tb_usb_packet_fsm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ctrl_pkg.sv
// Shared types for the USB packet controller: FSM states, error causes and
// the bundle of datapath control outputs decoded from each state.
package usb_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RX_SYNC_WAIT,
    S_RX_SYNC_CHK,
    S_RX_BYTE_WAIT,
    S_RX_WRITE,
    S_RX_CRC_CHK,
    S_RX_ERROR,
    S_TX_LOAD,
    S_TX_SEND,
    S_TX_HOLD,
    S_TX_READ,
    S_TX_CRC,
    S_TX_CRC_HOLD,
    S_TX_EOP
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_BAD_SYNC  = 3'd1,
    ERR_EARLY_EOP = 3'd2,
    ERR_CRC_FAIL  = 3'd3,
    ERR_OVERFLOW  = 3'd4,
    ERR_TIMEOUT   = 3'd5
  } err_e;

  typedef struct packed {
    logic receiving;
    logic write_enable;
    logic read_enable;
    logic load_enable;
    logic tx_enable;
    logic crc_enable;
    logic transmitting;
    logic in_out;
    logic create_eop;
    logic error;
    logic busy;
  } ctrl_t;

  // Moore decode: every control is a pure function of one state.
  function automatic ctrl_t decode(state_e s);
    ctrl_t c;
    c              = '0;
    c.receiving    = s inside {S_RX_SYNC_WAIT, S_RX_SYNC_CHK, S_RX_BYTE_WAIT,
                               S_RX_WRITE, S_RX_CRC_CHK, S_RX_ERROR};
    c.transmitting = s inside {S_TX_LOAD, S_TX_SEND, S_TX_HOLD, S_TX_READ,
                               S_TX_CRC, S_TX_CRC_HOLD, S_TX_EOP};
    c.in_out       = c.transmitting;
    c.write_enable = (s == S_RX_WRITE);
    c.read_enable  = (s == S_TX_READ);
    c.load_enable  = (s == S_TX_LOAD);
    c.tx_enable    = (s == S_TX_SEND);
    c.crc_enable   = (s == S_TX_CRC);
    c.create_eop   = (s == S_TX_EOP);
    c.error        = (s == S_RX_ERROR);
    c.busy         = (s != S_IDLE);
    return c;
  endfunction

endpackage

// File: rtl/usb_timeout_counter.sv
// Idle-line watchdog: counts enabled cycles and pulses tc_o on the cycle the
// count sits at TIMEOUT_CYCLES-1. clear_i wins over enable_i.
module usb_timeout_counter #(
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int W              = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of always-block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt_q <= '0;
    else if (clear_i)  cnt_q <= '0;
    else if (enable_i) cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o = enable_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/usb_packet_fsm.sv
// Single-packet USB link controller: sequences RX (sync check, byte writes,
// CRC check, error capture) and length-driven TX over the bit-level datapath.
module usb_packet_fsm
  import usb_ctrl_pkg::*;
#(
  parameter  int          DATA_W         = 8,
  parameter  int          MAX_BYTES      = 64,
  parameter  logic [7:0]  SYNC_PATTERN   = 8'b01010100,
  parameter  int          TIMEOUT_CYCLES = 1024,
  localparam int          CNT_W          = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_edge,
  input  logic              byte_received,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              eop,
  input  logic              crc_ok,
  input  logic              transmit_start,
  input  logic [CNT_W-1:0]  tx_len,
  input  logic              byte_sent,
  input  logic              tx_hold,
  input  logic              crc_sent,
  output logic              receiving,
  output logic              write_enable,
  output logic              read_enable,
  output logic              load_enable,
  output logic              tx_enable,
  output logic              crc_enable,
  output logic              transmitting,
  output logic              in_out,
  output logic              create_eop,
  output logic              error,
  output logic [2:0]        error_code,
  output logic [CNT_W-1:0]  rx_count,
  output logic              busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  state_e           state_q, state_d;
  err_e             err_q, err_d;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] rx_count_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic             to_tc;
  logic             leave_idle;

  // Clearing on every state change covers entry to RX_SYNC_WAIT and gives
  // RX_ERROR a fresh window for its own idle-exit.
  usb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (byte_received || (state_d != state_q)),
    .enable_i (state_q inside {S_RX_SYNC_WAIT, S_RX_BYTE_WAIT, S_RX_ERROR}),
    .tc_o     (to_tc)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (transmit_start) state_d = (tx_len == '0) ? S_TX_CRC : S_TX_LOAD;
        else if (d_edge)    state_d = S_RX_SYNC_WAIT;
        if (state_d != S_IDLE) err_d = ERR_NONE;
      end
      S_RX_SYNC_WAIT: begin
        if (byte_received) state_d = S_RX_SYNC_CHK;
        else if (to_tc) begin
          state_d = S_RX_ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_RX_SYNC_CHK: begin
        if (rx_data[7:0] == SYNC_PATTERN) state_d = S_RX_BYTE_WAIT;
        else begin
          state_d = S_RX_ERROR;
          err_d   = ERR_BAD_SYNC;
        end
      end
      S_RX_BYTE_WAIT: begin
        if (byte_received) begin
          if (rx_count_q == MAX_CNT) begin
            state_d = S_RX_ERROR;
            err_d   = ERR_OVERFLOW;
          end else begin
            state_d = S_RX_WRITE;
          end
        end else if (to_tc) begin
          state_d = S_RX_ERROR;
          err_d   = ERR_TIMEOUT;
        end else if (eop) begin
          if (rx_count_q >= CNT_W'(2)) state_d = S_RX_CRC_CHK;
          else begin
            state_d = S_RX_ERROR;
            err_d   = ERR_EARLY_EOP;
          end
        end
      end
      S_RX_WRITE:   state_d = S_RX_BYTE_WAIT;
      S_RX_CRC_CHK: begin
        if (crc_ok) state_d = S_IDLE;
        else begin
          state_d = S_RX_ERROR;
          err_d   = ERR_CRC_FAIL;
        end
      end
      S_RX_ERROR:    if (eop || to_tc) state_d = S_IDLE;
      S_TX_LOAD:     state_d = S_TX_SEND;
      S_TX_SEND: begin
        if (tx_hold)        state_d = S_TX_HOLD;
        else if (byte_sent) state_d = S_TX_READ;
      end
      S_TX_HOLD:     state_d = S_TX_SEND;
      S_TX_READ:     state_d = (tx_cnt_q == CNT_W'(1)) ? S_TX_CRC : S_TX_LOAD;
      S_TX_CRC:      state_d = crc_sent ? S_TX_EOP : S_TX_CRC_HOLD;
      S_TX_CRC_HOLD: state_d = S_TX_CRC;
      S_TX_EOP:      state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  assign leave_idle = (state_q == S_IDLE) && (state_d != S_IDLE);

  // NOTE: controls are registered from decode(state_d), so they change on the
  // same edge as state_q and are glitch-free Moore outputs of the new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      err_q      <= ERR_NONE;
      ctrl_q     <= '0;
      rx_count_q <= '0;
      tx_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      ctrl_q  <= decode(state_d);
      if (leave_idle)
        rx_count_q <= '0;
      else if (state_q == S_RX_WRITE && rx_count_q != MAX_CNT)
        rx_count_q <= rx_count_q + 1'b1;
      if (state_q == S_IDLE && transmit_start)
        tx_cnt_q <= tx_len;
      else if (state_q == S_TX_READ)
        tx_cnt_q <= tx_cnt_q - 1'b1;
    end
  end

  assign receiving    = ctrl_q.receiving;
  assign write_enable = ctrl_q.write_enable;
  assign read_enable  = ctrl_q.read_enable;
  assign load_enable  = ctrl_q.load_enable;
  assign tx_enable    = ctrl_q.tx_enable;
  assign crc_enable   = ctrl_q.crc_enable;
  assign transmitting = ctrl_q.transmitting;
  assign in_out       = ctrl_q.in_out;
  assign create_eop   = ctrl_q.create_eop;
  assign error        = ctrl_q.error;
  assign busy         = ctrl_q.busy;
  assign error_code   = err_q;
  assign rx_count     = rx_count_q;

endmodule

// File: tb/tb_usb_packet_fsm.sv
// Directed bench for usb_packet_fsm with MAX_BYTES=4 and TIMEOUT_CYCLES=16;
// inputs change 1 ns after a rising edge and outputs are checked there too.
module tb_usb_packet_fsm;

  localparam int CNT_W = 3;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             d_edge = 0, byte_received = 0, eop = 0, crc_ok = 0;
  logic [7:0]       rx_data = '0;
  logic             transmit_start = 0, byte_sent = 0, tx_hold = 0, crc_sent = 0;
  logic [CNT_W-1:0] tx_len = '0;
  logic             receiving, write_enable, read_enable, load_enable, tx_enable;
  logic             crc_enable, transmitting, in_out, create_eop, error, busy;
  logic [2:0]       error_code;
  logic [CNT_W-1:0] rx_count;

  int passed = 0;
  int total  = 0;
  int we_cnt = 0, ld_cnt = 0, rd_cnt = 0;
  int base_we, base_ld, base_rd;

  always #5 clk = ~clk;

  usb_packet_fsm #(
    .DATA_W(8), .MAX_BYTES(4), .SYNC_PATTERN(8'b01010100), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .d_edge(d_edge), .byte_received(byte_received),
    .rx_data(rx_data), .eop(eop), .crc_ok(crc_ok), .transmit_start(transmit_start),
    .tx_len(tx_len), .byte_sent(byte_sent), .tx_hold(tx_hold), .crc_sent(crc_sent),
    .receiving(receiving), .write_enable(write_enable), .read_enable(read_enable),
    .load_enable(load_enable), .tx_enable(tx_enable), .crc_enable(crc_enable),
    .transmitting(transmitting), .in_out(in_out), .create_eop(create_eop),
    .error(error), .error_code(error_code), .rx_count(rx_count), .busy(busy)
  );

  always @(negedge clk) begin
    if (write_enable) we_cnt++;
    if (load_enable)  ld_cnt++;
    if (read_enable)  rd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_byte(input logic [7:0] b);
    rx_data       = b;
    byte_received = 1'b1;
    tick();
    byte_received = 1'b0;
  endtask

  // IDLE -> RX_SYNC_WAIT -> RX_SYNC_CHK -> (next state after the check)
  task automatic start_rx(input logic [7:0] first);
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    strobe_byte(first);
    tick();
  endtask

  task automatic write_byte(input logic [7:0] b);
    strobe_byte(b);
    tick();
  endtask

  function automatic logic [10:0] ctrl_vec();
    return {receiving, write_enable, read_enable, load_enable, tx_enable,
            crc_enable, transmitting, in_out, create_eop, error, busy};
  endfunction

  initial begin
    tick();
    tick();
    check("reset_ctrl", ctrl_vec(), 11'b0);
    check("reset_code", error_code, 3'd0);
    rst = 1'b0;
    tick();
    check("idle_rx_count", rx_count, 3'd0);

    // Good packet: sync + 4 bytes + eop + crc_ok
    base_we = we_cnt;
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    check("d_edge_receiving", {receiving, busy}, 2'b11);
    strobe_byte(8'b01010100);
    tick();
    strobe_byte(8'hA1);
    check("first_write_enable", write_enable, 1'b1);
    tick();
    write_byte(8'hB2);
    write_byte(8'hC3);
    write_byte(8'hD4);
    check("good_rx_count", rx_count, 3'd4);
    eop = 1'b1;
    tick();
    eop    = 1'b0;
    crc_ok = 1'b1;
    tick();
    crc_ok = 1'b0;
    check("good_idle", {busy, error}, 2'b00);
    check("good_code", error_code, 3'd0);
    check("good_writes", we_cnt - base_we, 4);

    // Bad sync byte
    start_rx(8'hFF);
    check("bad_sync_error", error, 1'b1);
    check("bad_sync_code", error_code, 3'd1);
    check("bad_sync_rx_count_cleared", rx_count, 3'd0);
    eop = 1'b1;
    tick();
    eop = 1'b0;
    check("bad_sync_exit", {busy, error_code}, {1'b0, 3'd1});

    // Early eop after one byte
    start_rx(8'b01010100);
    write_byte(8'h11);
    eop = 1'b1;
    tick();
    check("early_eop_code", {error, error_code}, {1'b1, 3'd2});
    tick();
    eop = 1'b0;
    check("early_eop_exit", busy, 1'b0);

    // CRC failure
    start_rx(8'b01010100);
    write_byte(8'h21);
    write_byte(8'h22);
    eop = 1'b1;
    tick();
    eop = 1'b0;
    tick();
    check("crc_fail_code", {error, error_code}, {1'b1, 3'd3});
    eop = 1'b1;
    tick();
    eop = 1'b0;

    // Overflow: 5th byte with MAX_BYTES=4 is not written
    base_we = we_cnt;
    start_rx(8'b01010100);
    for (int i = 0; i < 4; i++) write_byte(8'h30 + 8'(i));
    strobe_byte(8'h3F);
    check("overflow_code", {error, error_code}, {1'b1, 3'd4});
    check("overflow_no_write", write_enable, 1'b0);
    check("overflow_writes", we_cnt - base_we, 4);
    check("overflow_rx_count", rx_count, 3'd4);
    eop = 1'b1;
    tick();
    eop = 1'b0;

    // Timeout after sync, then idle exit from RX_ERROR
    start_rx(8'b01010100);
    for (int i = 0; i < TO - 1; i++) tick();
    check("timeout_not_yet", error, 1'b0);
    tick();
    check("timeout_code", {error, error_code}, {1'b1, 3'd5});
    for (int i = 0; i < TO - 1; i++) tick();
    check("error_still_held", error, 1'b1);
    tick();
    check("error_idle_exit", {busy, error_code}, {1'b0, 3'd5});

    // Transmit 3 bytes with one tx_hold
    base_ld = ld_cnt;
    base_rd = rd_cnt;
    transmit_start = 1'b1;
    tx_len         = 3'd3;
    tick();
    transmit_start = 1'b0;
    check("tx_load", {load_enable, transmitting, in_out}, 3'b111);
    check("tx_clears_code", error_code, 3'd0);
    tick();
    check("tx_send", tx_enable, 1'b1);
    tx_hold = 1'b1;
    tick();
    tx_hold = 1'b0;
    check("tx_hold_state", {tx_enable, transmitting}, 2'b01);
    tick();
    for (int i = 0; i < 3; i++) begin
      byte_sent = 1'b1;
      tick();
      byte_sent = 1'b0;
      tick();
      if (i < 2) tick();
    end
    check("tx_crc", crc_enable, 1'b1);
    tick();
    check("tx_crc_hold", {crc_enable, transmitting}, 2'b01);
    tick();
    crc_sent = 1'b1;
    tick();
    crc_sent = 1'b0;
    check("tx_eop", create_eop, 1'b1);
    tick();
    check("tx_done", {create_eop, busy}, 2'b00);
    check("tx_loads", ld_cnt - base_ld, 3);
    check("tx_reads", rd_cnt - base_rd, 3);

    // Zero-length transmit goes straight to CRC
    transmit_start = 1'b1;
    tx_len         = 3'd0;
    tick();
    transmit_start = 1'b0;
    check("tx_len0_crc", {crc_enable, load_enable}, 2'b10);
    crc_sent = 1'b1;
    tick();
    crc_sent = 1'b0;
    tick();

    // TX beats RX on the same cycle; reset mid-TX aborts
    transmit_start = 1'b1;
    d_edge         = 1'b1;
    tx_len         = 3'd2;
    tick();
    transmit_start = 1'b0;
    d_edge         = 1'b0;
    check("tx_priority", {transmitting, receiving}, 2'b10);
    tick();
    rst = 1'b1;
    #1;
    check("mid_tx_reset_ctrl", ctrl_vec(), 11'b0);
    check("mid_tx_reset_regs", {error_code, rx_count}, 6'b0);
    tick();
    rst = 1'b0;
    tick();
    check("post_reset_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
